// File: rtl/upsampling_pkg.sv
// Shared definitions for the 2x bilinear upsampler.
// Boundary modes, phase encoding and the sum-width helper.
package upsampling_pkg;

  localparam logic [3:0] MODE_INTERIOR     = 4'd0;
  localparam logic [3:0] MODE_TOP_LEFT     = 4'd1;
  localparam logic [3:0] MODE_TOP          = 4'd2;
  localparam logic [3:0] MODE_TOP_RIGHT    = 4'd3;
  localparam logic [3:0] MODE_LEFT         = 4'd4;
  localparam logic [3:0] MODE_RIGHT        = 4'd5;
  localparam logic [3:0] MODE_BOTTOM_LEFT  = 4'd6;
  localparam logic [3:0] MODE_BOTTOM       = 4'd7;
  localparam logic [3:0] MODE_BOTTOM_RIGHT = 4'd8;

  // Encoded as {row odd, column odd}
  typedef enum logic [1:0] {
    PH_EVEN_EVEN = 2'b00,
    PH_EVEN_ODD  = 2'b01,
    PH_ODD_EVEN  = 2'b10,
    PH_ODD_ODD   = 2'b11
  } phase_t;

  function automatic int sum_width(input int len);
    return len + 2;
  endfunction

endpackage

// File: rtl/upsample_kernel.sv
// Combinational bilinear kernel: edge clamping, phase select, rounding.
// Half-up rounding when REG_OUTPUT_ROUND_EN is defined, else floor.
module upsample_kernel
  import upsampling_pkg::*;
#(
  parameter int length = 16
) (
  input  logic [length-1:0] i_d5,
  input  logic [length-1:0] i_d6,
  input  logic [length-1:0] i_d8,
  input  logic [length-1:0] i_d9,
  input  logic [3:0]        i_mode,
  input  logic              i_row_even,
  input  logic              i_col_even,
  output logic [length-1:0] o_pix
);

  localparam int SW = sum_width(length);

`ifdef REG_OUTPUT_ROUND_EN
  localparam logic [SW-1:0] RND2 = SW'(1);
  localparam logic [SW-1:0] RND4 = SW'(2);
`else
  localparam logic [SW-1:0] RND2 = '0;
  localparam logic [SW-1:0] RND4 = '0;
`endif

  logic              w_right;
  logic              w_bottom;
  logic              w_valid;
  logic [length-1:0] w_c6;
  logic [length-1:0] w_c8;
  logic [length-1:0] w_c9;
  logic [SW-1:0]     w_s_h;
  logic [SW-1:0]     w_s_v;
  logic [SW-1:0]     w_s_q;
  phase_t            w_ph;

  always_comb begin
    w_right  = 1'b0;
    w_bottom = 1'b0;
    w_valid  = 1'b1;
    unique case (i_mode)
      MODE_TOP_RIGHT,
      MODE_RIGHT:        w_right = 1'b1;
      MODE_BOTTOM_LEFT,
      MODE_BOTTOM:       w_bottom = 1'b1;
      MODE_BOTTOM_RIGHT: begin
        w_right  = 1'b1;
        w_bottom = 1'b1;
      end
      MODE_INTERIOR,
      MODE_TOP_LEFT,
      MODE_TOP,
      MODE_LEFT:         w_valid = 1'b1;
      default:           w_valid = 1'b0;
    endcase
  end

  // Only right/below neighbours feed the kernel,
  // so top/left modes need no clamping.
  assign w_c6 = w_right  ? i_d5 : i_d6;
  assign w_c8 = w_bottom ? i_d5 : i_d8;
  assign w_c9 = (w_right && w_bottom) ? i_d5 :
                w_right  ? w_c8 :
                w_bottom ? w_c6 : i_d9;

  assign w_s_h = {2'b00, i_d5} + {2'b00, w_c6} + RND2;
  assign w_s_v = {2'b00, i_d5} + {2'b00, w_c8} + RND2;
  assign w_s_q = {2'b00, i_d5} + {2'b00, w_c6}
               + {2'b00, w_c8} + {2'b00, w_c9} + RND4;

  assign w_ph = phase_t'({~i_row_even, ~i_col_even});

  always_comb begin
    o_pix = '0;
    if (w_valid) begin
      unique case (w_ph)
        PH_EVEN_EVEN: o_pix = i_d5;
        PH_EVEN_ODD:  o_pix = length'(w_s_h >> 1);
        PH_ODD_EVEN:  o_pix = length'(w_s_v >> 1);
        PH_ODD_ODD:   o_pix = length'(w_s_q >> 2);
      endcase
    end
  end

endmodule

// File: rtl/reg_output.sv
// Output register stage of the 2x bilinear upsampler.
// Optional half-up rounding via REG_OUTPUT_ROUND_EN.
module reg_output
  import upsampling_pkg::*;
#(
  parameter int length = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        write_mode,
  input  logic              row_even,
  input  logic [length-1:0] data_in1,
  input  logic [length-1:0] data_in2,
  input  logic [length-1:0] data_in3,
  input  logic [length-1:0] data_in4,
  input  logic [length-1:0] data_in5,
  input  logic [length-1:0] data_in6,
  input  logic [length-1:0] data_in7,
  input  logic [length-1:0] data_in8,
  input  logic [length-1:0] data_in9,
  output logic [length-1:0] dout
);

  logic              coloumn_even;
  logic [length-1:0] w_pix;
  logic              w_unused;

  // Upper/left window taps are not used by this kernel.
  assign w_unused = ^{data_in1, data_in2, data_in3,
                      data_in4, data_in7};

  upsample_kernel #(
    .length(length)
  ) u_kernel (
    .i_d5       (data_in5),
    .i_d6       (data_in6),
    .i_d8       (data_in8),
    .i_d9       (data_in9),
    .i_mode     (write_mode),
    .i_row_even (row_even),
    .i_col_even (coloumn_even),
    .o_pix      (w_pix)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout         <= '0;
      coloumn_even <= 1'b1;
    end else begin
      dout         <= w_pix;
      coloumn_even <= ~coloumn_even;
    end
  end

endmodule

// File: tb/tb_reg_output.sv
// Self-checking bench for reg_output: directed plan plus
// randomized steps against a behavioural model.
module tb_reg_output;

  logic        clk;
  logic        rst;
  logic [3:0]  mode;
  logic        row;
  logic [15:0] d [1:9];
  logic [15:0] dout;

  int checks;
  int failures;
  bit mcol;

  reg_output #(.length(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_mode (mode),
    .row_even   (row),
    .data_in1   (d[1]),
    .data_in2   (d[2]),
    .data_in3   (d[3]),
    .data_in4   (d[4]),
    .data_in5   (d[5]),
    .data_in6   (d[6]),
    .data_in7   (d[7]),
    .data_in8   (d[8]),
    .data_in9   (d[9]),
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(
    input int m, input bit r, input bit c,
    input longint a5, input longint a6,
    input longint a8, input longint a9);
    longint c5, c6, c8, c9, v, r2, r4;
    r2 = 0;
    r4 = 0;
`ifdef REG_OUTPUT_ROUND_EN
    r2 = 1;
    r4 = 2;
`endif
    if (m > 8) return 16'h0;
    c5 = a5;
    c6 = (m == 3 || m == 5 || m == 8) ? c5 : a6;
    c8 = (m == 6 || m == 7 || m == 8) ? c5 : a8;
    case (m)
      3, 5:    c9 = c8;
      6, 7:    c9 = c6;
      8:       c9 = c5;
      default: c9 = a9;
    endcase
    if (r && c)  v = c5;
    else if (r)  v = (c5 + c6 + r2) / 2;
    else if (c)  v = (c5 + c8 + r2) / 2;
    else         v = (c5 + c6 + c8 + c9 + r4) / 4;
    return v[15:0];
  endfunction

  task automatic step(input string tag, input logic [3:0] m,
                      input logic r, input logic [15:0] exp);
    mode = m;
    row  = r;
    @(posedge clk);
    #1;
    chk(tag, dout, exp);
    mcol = !mcol;
    chk({tag, "_phase"}, {15'h0, dut.coloumn_even}, {15'h0, mcol});
  endtask

  task automatic set_ramp();
    for (int i = 1; i <= 9; i++) d[i] = 16'(i);
  endtask

  initial begin
    logic [15:0] e;
    checks   = 0;
    failures = 0;
    rst  = 1'b0;
    mode = 4'd0;
    row  = 1'b0;
    for (int i = 1; i <= 9; i++) d[i] = 16'h0;
    #12;
    chk("reset_dout", dout, 16'h0);
    chk("reset_phase", {15'h0, dut.coloumn_even}, 16'h1);
    @(negedge clk);
    rst  = 1'b1;
    mcol = 1'b1;

    set_ramp();
`ifdef REG_OUTPUT_ROUND_EN
    step("m0_r0_ce", 4'd0, 1'b0, 16'd7);
    step("m0_r0_co", 4'd0, 1'b0, 16'd7);
    step("m0_r1_ce", 4'd0, 1'b1, 16'd5);
    step("m0_r1_co", 4'd0, 1'b1, 16'd6);
    step("m5_ce",    4'd5, 1'b0, 16'd7);
    step("m5_co",    4'd5, 1'b0, 16'd7);
    step("m7_ce",    4'd7, 1'b0, 16'd5);
    step("m7_co",    4'd7, 1'b0, 16'd6);
`else
    step("m0_r0_ce", 4'd0, 1'b0, 16'd6);
    step("m0_r0_co", 4'd0, 1'b0, 16'd7);
    step("m0_r1_ce", 4'd0, 1'b1, 16'd5);
    step("m0_r1_co", 4'd0, 1'b1, 16'd5);
    step("m5_ce",    4'd5, 1'b0, 16'd6);
    step("m5_co",    4'd5, 1'b0, 16'd6);
    step("m7_ce",    4'd7, 1'b0, 16'd5);
    step("m7_co",    4'd7, 1'b0, 16'd5);
`endif
    step("m8_ee", 4'd8, 1'b1, 16'd5);
    step("m8_eo", 4'd8, 1'b1, 16'd5);
    step("m8_oe", 4'd8, 1'b0, 16'd5);
    step("m8_oo", 4'd8, 1'b0, 16'd5);
    step("m9_a",  4'd9, 1'b0, 16'd0);
    step("m9_b",  4'd9, 1'b1, 16'd0);
    step("m15_a", 4'd15, 1'b0, 16'd0);

    // Mid-stream async reset between edges (phase currently odd)
    mode = 4'd0;
    row  = 1'b0;
    @(posedge clk);
    mcol = !mcol;
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_dout", dout, 16'h0);
    chk("midrst_phase", {15'h0, dut.coloumn_even}, 16'h1);
    @(posedge clk);
    #3;
    chk("midrst_hold", dout, 16'h0);
    rst  = 1'b1;
    mcol = 1'b1;
`ifdef REG_OUTPUT_ROUND_EN
    step("post_rst_even", 4'd0, 1'b0, 16'd7);
`else
    step("post_rst_even", 4'd0, 1'b0, 16'd6);
`endif

    for (int i = 1; i <= 9; i++) d[i] = 16'hFFFF;
    if (mcol) step("max_pad", 4'd0, 1'b0, 16'hFFFF);
    step("max_oo", 4'd0, 1'b0, 16'hFFFF);
    step("max_oe", 4'd0, 1'b0, 16'hFFFF);

    for (int n = 0; n < 300; n++) begin
      logic [3:0] m;
      logic       r;
      for (int i = 1; i <= 9; i++) d[i] = 16'($urandom);
      m = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                      : 4'($urandom_range(0, 8));
      r = 1'($urandom);
      e = model(int'(m), r, mcol, longint'(d[5]), longint'(d[6]),
                longint'(d[8]), longint'(d[9]));
      step("rand", m, r, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
